// File: rtl/mac_lane_array.sv
// mac_lane_array: LANES parallel pipelined signed MAC lanes producing framed dot products.
// Define MAC_SATURATE_EN to clamp overflowing products and sums instead of wrapping.
module mac_lane_array #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [LANES*WIDTH-1:0] in_seed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_ovf,
    output logic [CNT_W-1:0]       out_count
);
`ifdef MAC_SATURATE_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic stall;
    logic accept;
    logic advance;

    logic                          s1_valid_q, s1_valid_d;
    logic                          s1_first_q, s1_first_d;
    logic                          s1_last_q, s1_last_d;
    logic [LANES-1:0][2*WIDTH-1:0] s1_prod_q, s1_prod_d;
    logic [LANES-1:0][WIDTH-1:0]   s1_seed_q, s1_seed_d;

    logic [LANES-1:0][WIDTH-1:0]   acc_q, acc_d;
    logic [LANES-1:0]              ovf_q, ovf_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    logic                          out_valid_q, out_valid_d;
    logic [LANES*WIDTH-1:0]        out_data_q, out_data_d;
    logic [LANES-1:0]              out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]              out_count_q, out_count_d;

    logic [2*WIDTH-1:0]            a_ext, b_ext;
    logic [2*WIDTH-1:0]            prod;
    logic [WIDTH-1:0]              addend, base, sum;
    logic                          prod_ovf, add_ovf;

    // A pending result that is not being taken freezes the whole pipeline.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && !stall;
    assign advance  = s1_valid_q && !stall;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_prod_d  = s1_prod_q;
        s1_seed_d  = s1_seed_q;
        a_ext      = '0;
        b_ext      = '0;
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_first_d = in_first;
                s1_last_d  = in_last;
                for (int i = 0; i < LANES; i++) begin
                    a_ext = {{WIDTH{in_a[i*WIDTH+WIDTH-1]}}, in_a[i*WIDTH +: WIDTH]};
                    b_ext = {{WIDTH{in_b[i*WIDTH+WIDTH-1]}}, in_b[i*WIDTH +: WIDTH]};
                    s1_prod_d[i] = a_ext * b_ext;
                    s1_seed_d[i] = in_seed[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Accumulate stage; a last element copies the freshly computed totals into the output register.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        prod        = '0;
        addend      = '0;
        base        = '0;
        sum         = '0;
        prod_ovf    = 1'b0;
        add_ovf     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            prod     = s1_prod_q[i];
            prod_ovf = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
            addend   = prod[WIDTH-1:0];
`ifdef MAC_SATURATE_EN
            if (prod_ovf) begin
                addend = prod[2*WIDTH-1] ? SMIN : SMAX;
            end
`endif
            base    = s1_first_q ? s1_seed_q[i] : acc_q[i];
            sum     = base + addend;
            add_ovf = (base[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != base[WIDTH-1]);
`ifdef MAC_SATURATE_EN
            if (add_ovf) begin
                sum = base[WIDTH-1] ? SMIN : SMAX;
            end
`endif
            if (advance) begin
                acc_d[i] = sum;
                ovf_d[i] = (s1_first_q ? 1'b0 : ovf_q[i]) | prod_ovf | add_ovf;
                if (s1_last_q) begin
                    out_data_d[i*WIDTH +: WIDTH] = sum;
                    out_ovf_d[i]                 = ovf_d[i];
                end
            end
        end
        if (advance) begin
            if (s1_first_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (s1_last_q) begin
                out_count_d = cnt_d;
            end
        end
        out_valid_d = (advance && s1_last_q) ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            s1_seed_q   <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
            out_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            s1_seed_q   <= s1_seed_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

endmodule
